ram_rw_scheduler: RTL and testbench
===================================

Name: ram_rw_scheduler

Overview:
Sequences the shared single-port 256x8 RAM between two key-driven requesters: a fill (write) job and a timed playback (read) job.
- Sits between the two key_filter outputs and the RAM IP.
- Feeds read data to the seven-segment display path (ds/oe/shcp/stcp driver).
- Write has priority over read. Playback resumes automatically after a fill if it is still armed.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width
DEPTH, 256, number of RAM words; the last address is DEPTH-1
CNT_MAX, 24'd9_999_999, read dwell count; each address is held CNT_MAX+1 cycles (0.2 s at 50 MHz)
RD_LAT, 2, RAM read latency in cycles from address to valid ram_rdata (1..4)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  synchronous reset, active-high
wr_req  in  1  one-cycle pulse from the write key filter
rd_req  in  1  one-cycle pulse from the read key filter; toggles playback
ram_addr  out  ADDR_W  RAM address
ram_wren  out  1  RAM write enable
ram_wdata  out  DATA_W  RAM write data
ram_rden  out  1  RAM read enable
ram_rdata  in  DATA_W  RAM read data
disp_data  out  DATA_W  value to display
disp_valid  out  1  one-cycle strobe when disp_data updates
busy_wr  out  1  high while a fill is in progress

Behaviour:
- All outputs are registered. A request sampled at edge N takes effect on the outputs after edge N+1.
- Reset: state=IDLE, rd_armed=0, cnt=0, lat pipe=0, and every output is 0 (including disp_data). Reset mid-fill or mid-read aborts immediately. A partial fill is not completed.
- States: IDLE, WRITE, READ.
- IDLE:
  - ram_wren=0, ram_rden=0, ram_addr=0.
  - wr_req -> WRITE.
  - rd_req -> READ and rd_armed=1.
- WRITE:
  - busy_wr=1. ram_wren=1 for exactly DEPTH consecutive cycles.
  - ram_addr counts 0..DEPTH-1. ram_wdata = ram_addr[DATA_W-1:0].
  - On the cycle that writes address DEPTH-1: go to READ if rd_armed, else IDLE. busy_wr and ram_wren drop together.
  - wr_req during WRITE is ignored; there is no restart.
  - rd_req during WRITE toggles rd_armed only.
- READ:
  - ram_rden=1. On entry, ram_addr=0 and cnt=0.
  - cnt counts 0..CNT_MAX. When cnt==CNT_MAX, cnt goes to 0 and ram_addr increments, wrapping DEPTH-1 -> 0.
  - rd_req -> IDLE and rd_armed=0. ram_rden drops on the next cycle.
  - wr_req -> WRITE. rd_armed stays 1, so playback restarts at address 0 after the fill.
- Read capture:
  - A shift register of length RD_LAT takes a 1 on every cycle a new address is issued in READ (entry or increment).
  - When the pipe output is 1: disp_data <= ram_rdata and disp_valid=1 for one cycle.
  - The pipe is cleared when leaving READ, so in-flight reads are discarded.
  - disp_data holds its last value outside READ.
- Simultaneous wr_req and rd_req: wr_req wins the state transition. rd_req applies its rd_armed toggle (IDLE: arm; READ: disarm; WRITE: toggle).
- Reading before any fill returns unspecified RAM contents; no special handling.

Test Plan:
- Reset: assert sys_rst 3 cycles, deassert -> all outputs 0, ram_rden=0, state IDLE.
- Fill in IDLE: wr_req pulse -> ram_wren high 256 consecutive cycles, ram_addr/ram_wdata 0,1,..,255. busy_wr then falls, state returns to IDLE, no ram_rden.
- Playback after fill (CNT_MAX=9, RD_LAT=2): rd_req pulse ->
  - ram_addr=0 held 10 cycles, then 1, 2, ...
  - disp_valid pulses 2 cycles after each address change with disp_data equal to that address.
  - After 2560 cycles the address wraps 255->0 and disp_data=0.
- Stop: rd_req during READ at address 5 -> ram_rden=0 next cycle, disp_data stays 5, no further disp_valid.
- Fill pre-empts read: wr_req at address 37 during READ -> 256-cycle fill starts next cycle with no in-flight disp_valid, then READ resumes at address 0. A second variant pulses rd_req during the fill -> ends in IDLE.
- Simultaneous wr_req+rd_req in IDLE -> WRITE then READ. Reset asserted at fill address 100 -> ram_wren=0 the cycle after reset is sampled, IDLE.

Source files
------------

// File: rtl/ram_rw_scheduler.sv
// ram_rw_scheduler
//   Arbitrates a shared single-port RAM between a fill job (writes the
//   address pattern into every word) and a timed playback job (steps
//   through the RAM, holding each address CNT_MAX+1 cycles, and forwards
//   the read data to the display path). Write has priority; playback
//   restarts from address 0 after a fill if it is still armed.
//
// Ports
//   sys_clk    in   system clock
//   sys_rst    in   synchronous reset, active-high
//   wr_req     in   one-cycle pulse: start a fill
//   rd_req     in   one-cycle pulse: toggle playback
//   ram_addr   out  RAM address
//   ram_wren   out  RAM write enable
//   ram_wdata  out  RAM write data
//   ram_rden   out  RAM read enable
//   ram_rdata  in   RAM read data
//   disp_data  out  value to display
//   disp_valid out  one-cycle strobe when disp_data updates
//   busy_wr    out  high while a fill is in progress
module ram_rw_scheduler #(
    parameter int          ADDR_W  = 8,
    parameter int          DATA_W  = 8,
    parameter int          DEPTH   = 256,
    parameter logic [23:0] CNT_MAX = 24'd9_999_999,
    parameter int          RD_LAT  = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              wr_req,
    input  logic              rd_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              busy_wr
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0]        state, state_nxt;
    logic              rd_armed, armed_nxt;
    logic [23:0]       cnt, cnt_nxt;
    logic [RD_LAT-1:0] lat_pipe, pipe_nxt;
    logic              wr_q, rd_q;

    logic [ADDR_W-1:0] addr_nxt, addr_inc;
    logic [DATA_W-1:0] wdata_nxt, disp_nxt;
    logic              wren_nxt, rden_nxt, busy_nxt, valid_nxt;
    logic              issue;

    assign addr_inc = (ram_addr == LAST_ADDR) ? '0 : ram_addr + 1'b1;

    always_comb begin
        state_nxt = state;
        armed_nxt = rd_armed;
        cnt_nxt   = cnt;
        addr_nxt  = '0;
        wdata_nxt = '0;
        wren_nxt  = 1'b0;
        rden_nxt  = 1'b0;
        busy_nxt  = 1'b0;
        issue     = 1'b0;
        disp_nxt  = disp_data;
        valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (rd_q)
                    armed_nxt = 1'b1;
                if (wr_q)
                    state_nxt = WRITE;
                else if (rd_q)
                    state_nxt = READ;
            end
            WRITE: begin
                // rd_req only toggles arming; the fill always runs to the end
                armed_nxt = rd_armed ^ rd_q;
                if (ram_addr == LAST_ADDR)
                    state_nxt = armed_nxt ? READ : IDLE;
                else
                    addr_nxt = addr_inc;
            end
            READ: begin
                if (rd_q)
                    armed_nxt = 1'b0;
                if (wr_q) begin
                    state_nxt = WRITE;
                end else if (rd_q) begin
                    state_nxt = IDLE;
                end else begin
                    addr_nxt = ram_addr;
                    if (cnt == CNT_MAX) begin
                        cnt_nxt  = '0;
                        addr_nxt = addr_inc;
                        issue    = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                    // capture only while staying in READ: leaving drops in-flight reads
                    if (lat_pipe[RD_LAT-1]) begin
                        disp_nxt  = ram_rdata;
                        valid_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Output image for the state being entered or held
        if (state_nxt == WRITE) begin
            wren_nxt  = 1'b1;
            busy_nxt  = 1'b1;
            wdata_nxt = DATA_W'(addr_nxt);
        end
        if (state_nxt == READ) begin
            rden_nxt = 1'b1;
            if (state != READ) begin
                cnt_nxt = '0;
                issue   = 1'b1;
            end
        end

        pipe_nxt = (state_nxt == READ) ? ((lat_pipe << 1) | RD_LAT'(issue)) : '0;
    end

    // Requests are registered first, so a pulse acts one edge after it is sampled.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            state      <= IDLE;
            rd_armed   <= 1'b0;
            cnt        <= '0;
            lat_pipe   <= '0;
            ram_addr   <= '0;
            ram_wren   <= 1'b0;
            ram_wdata  <= '0;
            ram_rden   <= 1'b0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            busy_wr    <= 1'b0;
        end else begin
            wr_q       <= wr_req;
            rd_q       <= rd_req;
            state      <= state_nxt;
            rd_armed   <= armed_nxt;
            cnt        <= cnt_nxt;
            lat_pipe   <= pipe_nxt;
            ram_addr   <= addr_nxt;
            ram_wren   <= wren_nxt;
            ram_wdata  <= wdata_nxt;
            ram_rden   <= rden_nxt;
            disp_data  <= disp_nxt;
            disp_valid <= valid_nxt;
            busy_wr    <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_ram_rw_scheduler.sv
// tb_ram_rw_scheduler
//   Self-checking bench for ram_rw_scheduler with a short dwell (CNT_MAX=9)
//   and a one-stage registered RAM (RD_LAT=2). A request-level reference
//   model predicts every output each cycle.
`timescale 1ns/1ps
module tb_ram_rw_scheduler;

    localparam int          ADDR_W  = 8;
    localparam int          DATA_W  = 8;
    localparam int          DEPTH   = 256;
    localparam logic [23:0] CNT_MAX = 24'd9;
    localparam int          RD_LAT  = 2;
    localparam int          DWELL   = 10;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              wr_req  = 1'b0;
    logic              rd_req  = 1'b0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_rden;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              busy_wr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    ram_rw_scheduler #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_MAX(CNT_MAX),
        .RD_LAT (RD_LAT)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .wr_req    (wr_req),
        .rd_req    (rd_req),
        .ram_addr  (ram_addr),
        .ram_wren  (ram_wren),
        .ram_wdata (ram_wdata),
        .ram_rden  (ram_rden),
        .ram_rdata (ram_rdata),
        .disp_data (disp_data),
        .disp_valid(disp_valid),
        .busy_wr   (busy_wr)
    );

    // RAM: data appears one cycle after the address (two-cycle capture path)
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] ram_q;
    always @(posedge sys_clk) begin
        if (ram_wren)
            ram[ram_addr] <= ram_wdata;
        ram_q <= ram[ram_addr];
    end
    assign ram_rdata = ram_q;

    // ---------------- reference model ----------------
    int   now = 0;
    bit   m_wr_d = 0, m_rd_d = 0, m_w = 0, m_r = 0;
    bit   m_writing = 0, m_reading = 0, m_armed = 0;
    int   m_wpos = 0, m_tick = 0;
    logic [DATA_W-1:0] m_mem [DEPTH];
    int   pend_due[$];
    int   pend_addr[$];
    logic [ADDR_W-1:0] e_addr = '0;
    logic [DATA_W-1:0] e_wdata = '0, e_disp = '0;
    logic e_wren = 0, e_rden = 0, e_valid = 0, e_busy = 0;

    function void m_start_write();
        m_writing = 1; m_wpos = 0; m_mem[0] = '0;
        e_addr = '0; e_wdata = '0; e_wren = 1; e_busy = 1; e_rden = 0;
    endfunction

    function void m_start_read();
        pend_due.delete(); pend_addr.delete();
        m_reading = 1; m_tick = 0;
        e_addr = '0; e_wdata = '0; e_rden = 1; e_wren = 0; e_busy = 0;
        pend_due.push_back(now + RD_LAT); pend_addr.push_back(0);
    endfunction

    always @(posedge sys_clk) begin
        m_w = m_wr_d; m_r = m_rd_d;
        m_wr_d = wr_req; m_rd_d = rd_req;
        now++;
        e_valid = 0;
        if (sys_rst) begin
            m_wr_d = 0; m_rd_d = 0; m_writing = 0; m_reading = 0; m_armed = 0;
            pend_due.delete(); pend_addr.delete();
            e_addr = '0; e_wdata = '0; e_disp = '0;
            e_wren = 0; e_rden = 0; e_busy = 0;
        end else if (m_writing) begin
            if (m_r) m_armed = !m_armed;
            if (m_wpos == DEPTH-1) begin
                m_writing = 0; e_wren = 0; e_busy = 0; e_wdata = '0; e_addr = '0;
                if (m_armed) m_start_read();
            end else begin
                m_wpos++;
                e_addr = ADDR_W'(m_wpos); e_wdata = DATA_W'(m_wpos);
                m_mem[m_wpos] = DATA_W'(m_wpos);
            end
        end else if (m_reading) begin
            if (m_w) begin
                if (m_r) m_armed = 0;
                m_reading = 0; pend_due.delete(); pend_addr.delete();
                m_start_write();
            end else if (m_r) begin
                m_armed = 0; m_reading = 0; pend_due.delete(); pend_addr.delete();
                e_rden = 0; e_addr = '0;
            end else begin
                m_tick++;
                if (pend_due.size() > 0 && pend_due[0] == now) begin
                    e_disp = m_mem[pend_addr[0]]; e_valid = 1;
                    void'(pend_due.pop_front()); void'(pend_addr.pop_front());
                end
                if (m_tick % DWELL == 0) begin
                    e_addr = ADDR_W'((m_tick / DWELL) % DEPTH);
                    pend_due.push_back(now + RD_LAT); pend_addr.push_back(int'(e_addr));
                end
            end
        end else begin
            if (m_w) begin
                if (m_r) m_armed = 1;
                m_start_write();
            end else if (m_r) begin
                m_armed = 1;
                m_start_read();
            end
        end
    end

    function automatic logic [27:0] dut_vec();
        return {ram_addr, ram_wren, ram_wdata, ram_rden, disp_data, disp_valid, busy_wr};
    endfunction

    function automatic logic [27:0] exp_vec();
        return {e_addr, e_wren, e_wdata, e_rden, e_disp, e_valid, e_busy};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        sys_rst = 1; wr_req = 0; rd_req = 0;
        repeat (3) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_hold @%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
        end
        sys_rst = 0;
        @(negedge sys_clk);
        n_cmp++;
        if (dut_vec() !== 28'h0) begin
            n_bad++;
            $display("FAIL reset_zero: got %h expected 0", dut_vec());
        end
    endtask

    task automatic test_fill();
        int wcount = 0;
        int rden_seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL fill_model @%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            if (ram_wren === 1'b1) begin
                n_cmp++;
                if (ram_addr !== 8'(wcount) || ram_wdata !== 8'(wcount)) begin
                    n_bad++;
                    $display("FAIL fill_seq: got addr %0d data %0d expected %0d", ram_addr, ram_wdata, wcount);
                end
                wcount++;
            end
            if (ram_rden !== 1'b0) rden_seen++;
            wr_req = (i == 0);
        end
        n_cmp++;
        if (wcount != 256) begin
            n_bad++;
            $display("FAIL fill_len: got %0d write cycles expected 256", wcount);
        end
        n_cmp++;
        if (busy_wr !== 1'b0 || rden_seen != 0) begin
            n_bad++;
            $display("FAIL fill_end: got busy %b rden cycles %0d expected 0 0", busy_wr, rden_seen);
        end
    endtask

    task automatic test_playback();
        int pulses = 0;
        for (int i = 0; i < 2640; i++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL play_model @%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            if (disp_valid === 1'b1) begin
                n_cmp++;
                if (disp_data !== 8'(pulses)) begin
                    n_bad++;
                    $display("FAIL play_data: got %0d expected %0d", disp_data, 8'(pulses));
                end
                pulses++;
            end
            rd_req = (i == 0);
        end
        n_cmp++;
        if (pulses != 264) begin
            n_bad++;
            $display("FAIL play_count: got %0d strobes expected 264", pulses);
        end
    endtask

    task automatic test_stop();
        bit found = 0;
        // stop the running playback, then restart it from IDLE
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL stop_model @%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            rd_req = (i == 0 || i == 5);
        end
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL stop_model @%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            if (disp_valid === 1'b1 && disp_data === 8'd5) found = 1;
            rd_req = found;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL stop_reach: got no display of 5 expected one");
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            rd_req = 0;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL stop_model @%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            if (i >= 1) begin
                n_cmp++;
                if (ram_rden !== 1'b0 || disp_valid !== 1'b0 || disp_data !== 8'd5) begin
                    n_bad++;
                    $display("FAIL stop_hold: got rden %b valid %b data %0d expected 0 0 5", ram_rden, disp_valid, disp_data);
                end
            end
        end
    endtask

    task automatic test_preempt();
        bit found = 0;
        int wcount = 0;
        int stray = 0;
        rd_req = 1;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL preempt_model @%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            rd_req = 0;
            if (ram_rden === 1'b1 && ram_addr === 8'd37) found = 1;
            wr_req = found;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL preempt_reach: got no address 37 expected one");
        end
        for (int i = 1; i <= 260; i++) begin
            @(negedge sys_clk);
            wr_req = 0;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL preempt_model @%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            if (ram_wren === 1'b1) wcount++;
            if (disp_valid === 1'b1 && i < 260) stray++;
            if (i == 259) begin
                n_cmp++;
                if (ram_rden !== 1'b1 || ram_addr !== 8'd0 || busy_wr !== 1'b0) begin
                    n_bad++;
                    $display("FAIL preempt_resume: got rden %b addr %0d busy %b expected 1 0 0", ram_rden, ram_addr, busy_wr);
                end
            end
            if (i == 260) begin
                n_cmp++;
                if (disp_valid !== 1'b1 || disp_data !== 8'd0) begin
                    n_bad++;
                    $display("FAIL preempt_first_read: got valid %b data %0d expected 1 0", disp_valid, disp_data);
                end
            end
        end
        n_cmp++;
        if (wcount != 256 || stray != 0) begin
            n_bad++;
            $display("FAIL preempt_fill: got %0d writes %0d strobes expected 256 0", wcount, stray);
        end

        // second variant: rd_req during the fill disarms playback
        found = 0; wcount = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL preempt2_model @%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            if (ram_rden === 1'b1 && ram_addr === 8'd10) found = 1;
            wr_req = found;
        end
        for (int i = 1; i <= 280; i++) begin
            @(negedge sys_clk);
            wr_req = 0;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL preempt2_model @%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            if (ram_wren === 1'b1) wcount++;
            rd_req = (i == 50);
        end
        n_cmp++;
        if (wcount != 256 || ram_rden !== 1'b0 || busy_wr !== 1'b0 || ram_addr !== 8'd0) begin
            n_bad++;
            $display("FAIL preempt2_idle: got %0d writes rden %b busy %b addr %0d expected 256 0 0 0", wcount, ram_rden, busy_wr, ram_addr);
        end
    endtask

    task automatic test_simultaneous();
        int wcount = 0;
        wr_req = 1; rd_req = 1;
        for (int i = 1; i <= 262; i++) begin
            @(negedge sys_clk);
            wr_req = 0; rd_req = 0;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL simul_model @%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            if (ram_wren === 1'b1) wcount++;
        end
        n_cmp++;
        if (wcount != 256 || ram_rden !== 1'b1 || ram_addr !== 8'd0) begin
            n_bad++;
            $display("FAIL simul_order: got %0d writes rden %b addr %0d expected 256 1 0", wcount, ram_rden, ram_addr);
        end
        rd_req = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            rd_req = 0;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL simul_model @%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (ram_rden !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_stop: got rden %b expected 0", ram_rden);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int active = 0;
        wr_req = 1;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge sys_clk);
            wr_req = 0;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL rstmid_model @%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            if (ram_wren === 1'b1 && ram_addr === 8'd100) found = 1;
            sys_rst = found;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL rstmid_reach: got no write at 100 expected one");
        end
        @(negedge sys_clk);
        n_cmp++;
        if (dut_vec() !== 28'h0) begin
            n_bad++;
            $display("FAIL rstmid_zero: got %h expected 0", dut_vec());
        end
        sys_rst = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL rstmid_model @%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            if (ram_wren !== 1'b0 || busy_wr !== 1'b0) active++;
        end
        n_cmp++;
        if (active != 0) begin
            n_bad++;
            $display("FAIL rstmid_no_resume: got %0d active cycles expected 0", active);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6000; i++) begin
            @(negedge sys_clk);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_model @%0t: got %h expected %h", $time, dut_vec(), exp_vec());
            end
            wr_req  = ($urandom_range(0, 299) == 0);
            rd_req  = ($urandom_range(0, 149) == 0);
            sys_rst = ($urandom_range(0, 1999) == 0);
        end
        wr_req = 0; rd_req = 0; sys_rst = 0;
        @(negedge sys_clk);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_playback();
        test_stop();
        test_preempt();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
